// File: rtl/atmo_light_frame_est_pkg.sv
// atmo_light_frame_est_pkg: shared packing helpers, reciprocal saturation limit and pipeline stage edges
package atmo_light_frame_est_pkg;
  localparam int S1_EDGE = 1;
  localparam int S2_EDGE = 2;
  localparam int S3_EDGE = 3;
  function automatic int pix_lsb(input int c, input int k, input int win, input int dw);
    return (c * win + k) * dw;
  endfunction
  function automatic int inv_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/atmo_light_frame_est_if.sv
// atmo_light_frame_est_if: window beat stream in (valid/sof/eof/pix/smooth_en), committed A/invA/dark_max out
interface atmo_light_frame_est_if #(
  parameter int DATA_W = 8,
  parameter int NCH = 3,
  parameter int WIN = 9,
  parameter int INV_W = 9
);
  logic in_valid;
  logic in_sof;
  logic in_eof;
  logic [NCH*WIN*DATA_W-1:0] in_pix;
  logic smooth_en;
  logic out_valid;
  logic [NCH*DATA_W-1:0] A;
  logic [NCH*INV_W-1:0] invA;
  logic [DATA_W-1:0] dark_max;
  modport master (
    output in_valid, in_sof, in_eof, in_pix, smooth_en,
    input out_valid, A, invA, dark_max
  );
  modport slave (
    input in_valid, in_sof, in_eof, in_pix, smooth_en,
    output out_valid, A, invA, dark_max
  );
endinterface

// File: rtl/atmo_light_frame_est_recip.sv
// atmo_recip_lut: combinational i_a -> o_inv = min(2^INV_W-1, floor(2^INV_SHIFT/i_a)), o_inv saturated for i_a=0
module atmo_recip_lut
  import atmo_light_frame_est_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int INV_W = 9,
  parameter int INV_SHIFT = 16
) (
  input  logic [DATA_W-1:0] i_a,
  output logic [INV_W-1:0]  o_inv
);
  function automatic logic [(2**DATA_W)*INV_W-1:0] build_lut();
    logic [(2**DATA_W)*INV_W-1:0] t;
    longint q;
    t = '0;
    for (int a = 0; a < 2**DATA_W; a++) begin
      q = (a == 0) ? longint'(inv_max(INV_W)) : (longint'(1) << INV_SHIFT) / longint'(a);
      if (q > longint'(inv_max(INV_W))) q = longint'(inv_max(INV_W));
      t[a*INV_W +: INV_W] = q[INV_W-1:0];
    end
    return t;
  endfunction
  localparam logic [(2**DATA_W)*INV_W-1:0] LUT = build_lut();
  assign o_inv = LUT[int'(i_a)*INV_W +: INV_W];
endmodule

// File: rtl/atmo_light_frame_est.sv
// atmo_light_frame_est: per-frame brightest dark-channel pixel -> A/invA/dark_max (clk, rst, io_bus slave)
module atmo_light_frame_est
  import atmo_light_frame_est_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH = 3,
  parameter int WIN = 9,
  parameter int INV_W = 9,
  parameter int INV_SHIFT = 16
) (
  input logic clk,
  input logic rst,
  atmo_light_frame_est_if.slave io_bus
);
  logic [NCH-1:0][DATA_W-1:0] w_min, r_s1_min, r_cand, r_s3_cand, w_cand, w_a_new, r_a;
  logic [NCH-1:0][INV_W-1:0] w_inv, r_inv;
  logic [DATA_W-1:0] w_dark, w_nd, r_dark, r_s3_dark, r_dmax;
  logic r_s1_v, r_s1_sof, r_s1_eof, r_open, r_s3_v, r_ov, r_have_prev, w_take, w_smooth;
  genvar c, k;
  for (c = 0; c < NCH; c++) begin : g_ch
    logic [WIN-1:0][DATA_W-1:0] w_red;
    for (k = 0; k < WIN; k++) begin : g_tap
      logic [DATA_W-1:0] w_tap;
      assign w_tap = io_bus.in_pix[pix_lsb(c, k, WIN, DATA_W) +: DATA_W];
      if (k == 0) begin : g_first
        assign w_red[k] = w_tap;
      end else begin : g_rest
        assign w_red[k] = (w_tap < w_red[k-1]) ? w_tap : w_red[k-1];
      end
    end
    assign w_min[c] = w_red[WIN-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1_sof <= 1'b0;
      r_s1_eof <= 1'b0;
      r_s1_min <= '0;
    end else begin
      r_s1_v <= io_bus.in_valid;
      r_s1_sof <= io_bus.in_valid & io_bus.in_sof;
      r_s1_eof <= io_bus.in_valid & io_bus.in_eof;
      r_s1_min <= w_min;
    end
  end
  always_comb begin
    w_dark = r_s1_min[0];
    for (int i = 1; i < NCH; i++) w_dark = (r_s1_min[i] < w_dark) ? r_s1_min[i] : w_dark;
    w_take = !r_open | r_s1_sof | (w_dark > r_dark);
    w_nd = w_take ? w_dark : r_dark;
    w_cand = w_take ? r_s1_min : r_cand;
  end
  // The final candidate is snapshotted when EOF leaves S2, so a following frame may start immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_open <= 1'b0;
      r_dark <= '0;
      r_cand <= '0;
      r_s3_v <= 1'b0;
      r_s3_dark <= '0;
      r_s3_cand <= '0;
    end else begin
      r_s3_v <= r_s1_v & r_s1_eof;
      if (r_s1_v) begin
        r_open <= !r_s1_eof;
        r_dark <= w_nd;
        r_cand <= w_cand;
        r_s3_dark <= w_nd;
        r_s3_cand <= w_cand;
      end
    end
  end
  assign w_smooth = io_bus.smooth_en & r_have_prev;
  for (c = 0; c < NCH; c++) begin : g_s3
    assign w_a_new[c] = w_smooth
      ? DATA_W'((({2'b0, r_a[c]} << 1) + {2'b0, r_a[c]} + {2'b0, r_s3_cand[c]} + (DATA_W+2)'(2)) >> 2)
      : r_s3_cand[c];
    atmo_recip_lut #(.DATA_W(DATA_W), .INV_W(INV_W), .INV_SHIFT(INV_SHIFT)) u_recip (
      .i_a(w_a_new[c]),
      .o_inv(w_inv[c])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov <= 1'b0;
      r_a <= '0;
      r_inv <= '0;
      r_dmax <= '0;
      r_have_prev <= 1'b0;
    end else begin
      r_ov <= r_s3_v;
      if (r_s3_v) begin
        r_a <= w_a_new;
        r_inv <= w_inv;
        r_dmax <= r_s3_dark;
        r_have_prev <= 1'b1;
      end
    end
  end
  assign io_bus.out_valid = r_ov;
  assign io_bus.A = r_a;
  assign io_bus.invA = r_inv;
  assign io_bus.dark_max = r_dmax;
endmodule

// File: tb/tb_atmo_light_frame_est.sv
// tb_atmo_light_frame_est: directed frames with hand-computed A/invA/dark_max checked by a scoreboard monitor
module tb_atmo_light_frame_est;
  import atmo_light_frame_est_pkg::*;
  localparam int DW = 8, NC = 3, WN = 9, IW = 9;
  localparam int PW = NC * WN * DW;
  typedef struct packed {
    logic [NC*DW-1:0] a;
    logic [NC*IW-1:0] inv;
    logic [DW-1:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exp_t e;
  int n;
  always #5 clk = ~clk;
  atmo_light_frame_est_if #(.DATA_W(DW), .NCH(NC), .WIN(WN), .INV_W(IW)) bus ();
  atmo_light_frame_est #(.DATA_W(DW), .NCH(NC), .WIN(WN), .INV_W(IW), .INV_SHIFT(16)) u_dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [PW-1:0] uni(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [PW-1:0] p;
    for (int k = 0; k < WN; k++) begin
      p[pix_lsb(0, k, WN, DW) +: DW] = r;
      p[pix_lsb(1, k, WN, DW) +: DW] = g;
      p[pix_lsb(2, k, WN, DW) +: DW] = b;
    end
    return p;
  endfunction
  task automatic beatp(input logic v, input logic s, input logic eo, input logic [PW-1:0] p);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof = s;
    bus.in_eof = eo;
    bus.in_pix = p;
  endtask
  task automatic beat(input logic s, input logic eo, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    beatp(1'b1, s, eo, uni(r, g, b));
  endtask
  task automatic idle(input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      bus.in_eof = 1'b0;
    end
  endtask
  task automatic push(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [8:0] i0, input logic [8:0] i1, input logic [8:0] i2, input logic [7:0] d);
    q.push_back({{a2, a1, a0}, {i2, i1, i0}, d});
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious out_valid: got 1 expected 0 at %0t (A=0x%0h)", $time, bus.A);
      end else begin
        e = q.pop_front();
        chk("A", 32'(bus.A), 32'(e.a));
        chk("invA", 32'(bus.invA), 32'(e.inv));
        chk("dark_max", 32'(bus.dark_max), 32'(e.d));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_eof = 1'b0;
    bus.in_pix = '0;
    bus.smooth_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset A", 32'(bus.A), 32'd0);
    chk("reset invA", 32'(bus.invA), 32'd0);
    chk("reset dark_max", 32'(bus.dark_max), 32'd0);
    push(210, 200, 230, 312, 327, 284, 200);
    beat(1, 0, 20, 20, 20);
    beat(0, 0, 210, 200, 230);
    beat(0, 1, 100, 100, 100);
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_eof = 1'b0;
      n++;
    end while (!bus.out_valid && n < 10);
    chk("latency", 32'(n), 32'(S3_EDGE));
    idle(3);
    bus.smooth_en = 1'b1;
    beat(1, 0, 100, 100, 100);
    beat(0, 0, 120, 120, 120);
    beat(0, 0, 130, 130, 130);
    beat(0, 1, 240, 240, 240);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_eof = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid-reset A", 32'(bus.A), 32'd0);
    chk("mid-reset invA", 32'(bus.invA), 32'd0);
    chk("mid-reset dark_max", 32'(bus.dark_max), 32'd0);
    push(50, 50, 50, 511, 511, 511, 50);
    beat(0, 1, 50, 50, 50);
    idle(5);
    bus.smooth_en = 1'b0;
    push(150, 160, 170, 436, 409, 385, 150);
    beat(1, 0, 150, 160, 170);
    beat(0, 1, 150, 180, 190);
    idle(5);
    begin
      logic [PW-1:0] p;
      p = uni(250, 250, 250);
      p[pix_lsb(0, 0, WN, DW) +: DW] = 8'd130;
      p[pix_lsb(1, 4, WN, DW) +: DW] = 8'd150;
      p[pix_lsb(2, 8, WN, DW) +: DW] = 8'd170;
      push(130, 150, 170, 504, 436, 385, 130);
      beatp(1, 1, 1, p);
      idle(5);
    end
    push(0, 0, 0, 511, 511, 511, 0);
    beat(1, 1, 0, 0, 0);
    idle(5);
    push(130, 130, 130, 504, 504, 504, 130);
    push(150, 150, 150, 436, 436, 436, 150);
    push(170, 170, 170, 385, 385, 385, 170);
    beat(1, 1, 130, 130, 130);
    beat(1, 1, 150, 150, 150);
    beat(1, 1, 170, 170, 170);
    idle(5);
    push(200, 200, 200, 327, 327, 327, 200);
    beat(1, 1, 200, 200, 200);
    idle(5);
    bus.smooth_en = 1'b1;
    push(175, 175, 175, 374, 374, 374, 100);
    beat(1, 1, 100, 100, 100);
    idle(5);
    bus.smooth_en = 1'b0;
    beatp(0, 1, 1, uni(255, 255, 255));
    beatp(0, 1, 1, uni(255, 255, 255));
    idle(5);
    chk("hold A", 32'(bus.A), 32'h00afafaf);
    chk("hold dark_max", 32'(bus.dark_max), 32'd100);
    push(140, 140, 140, 468, 468, 468, 140);
    beat(1, 0, 140, 140, 140);
    beatp(0, 1, 1, uni(255, 255, 255));
    beat(0, 1, 130, 130, 130);
    idle(5);
    push(180, 180, 180, 364, 364, 364, 180);
    beat(0, 0, 180, 180, 180);
    beat(0, 1, 160, 160, 160);
    idle(5);
    push(220, 220, 220, 297, 297, 297, 220);
    beat(1, 0, 230, 230, 230);
    beat(1, 0, 220, 220, 220);
    beat(0, 1, 120, 120, 120);
    idle(8);
    chk("pending commits", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/atmo_light_frame_est.md
Name: atmo_light_frame_est

Overview:
Parametrised, frame-aware successor to the three-channel atmospheric-light estimator. It takes a WIN-pixel neighbourhood per channel for NCH channels with valid/SOF/EOF framing. Per frame, it tracks the pixel whose dark-channel value (min over window, then min over channels) is largest. At frame end it commits per-channel A and saturated reciprocal invA, with optional frame-to-frame smoothing. It sits between the line-buffer/window generator and the transmission/recovery stages.

Parameters:
DATA_W, 8, pixel component width
NCH, 3, channel count (>=1)
WIN, 9, pixels per window per channel (>=1)
INV_W, 9, reciprocal output width
INV_SHIFT, 16, reciprocal numerator exponent: invA = floor(2^INV_SHIFT / A)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  window beat valid
in_sof  in  1  first beat of frame (qualified by in_valid)
in_eof  in  1  last beat of frame (qualified by in_valid)
in_pix  in  NCH*WIN*DATA_W  channel c, tap k at bits [(c*WIN+k)*DATA_W +: DATA_W]
smooth_en  in  1  enable frame-to-frame IIR on A
out_valid  out  1  one-cycle pulse: A/invA/dark_max updated
A  out  NCH*DATA_W  committed atmospheric light, channel c at [c*DATA_W +: DATA_W]
invA  out  NCH*INV_W  committed reciprocal, channel c at [c*INV_W +: INV_W]
dark_max  out  DATA_W  max dark-channel value of last committed frame

Behaviour:
- Reset (sync, rst=1 at edge): out_valid, A, invA, dark_max, all pipeline regs, running max, frame-first flag, have_prev cleared to 0. Reset mid-frame discards the frame; no commit until the next EOF.
- Beats with in_valid=0 are ignored entirely, including any sof/eof.
- S1, edge after an accepted beat at cycle t: register per-channel min over WIN taps, plus valid/sof/eof.
- S2, edge t+2: dark = min over the NCH S1 mins. Update the running candidate (dark and per-channel S1 mins) if the beat is SOF, the first beat since the last commit, or dark > running dark. Ties keep the earlier pixel.
- S3, edge t+3, only if the S2 beat was EOF: commit.
  - A_new[c] = cand[c], or (3*A[c] + cand[c] + 2) >> 2 if smooth_en=1 and have_prev=1.
  - invA[c] = 2^INV_W-1 if A_new[c]=0; otherwise min(2^INV_W-1, floor(2^INV_SHIFT / A_new[c])).
  - dark_max = running dark; out_valid=1 for this cycle only; have_prev set; first flag set.
- Outputs hold between commits; out_valid=0 otherwise.
- Latency: EOF beat at cycle t drives out_valid high during cycle t+3. New beats can be accepted every cycle with no stall. A SOF accepted while a previous EOF is still in flight does not disturb that commit.
- SOF+EOF on the same beat: single-pixel frame; commit from that pixel.
- SOF mid-frame: restarts the running max and drops the partial frame.
- EOF without a prior SOF: commit from the beats since the last commit/reset.
- smooth_en is sampled at S3.
- All compares are unsigned. The smoothing sum needs DATA_W+2 bits.

Decomposition:
- Shared package: slice helpers for in_pix/A/invA packing, INV_MAX = 2^INV_W-1, pipeline-stage index constants.
- One sub-module: atmo_recip_lut (parametrised DATA_W/INV_W/INV_SHIFT, combinational, generated by a constant function), instantiated NCH times after the smoothing mux.
- min_9 generalises to a parametrised min tree in generate loops inside the top.

Test Plan:
- Reset mid-frame: 4 beats, then rst=1 for 1 cycle, then EOF beat with all taps = 50 -> no out_valid from the aborted frame. Next commit: A=50/50/50, invA=1310 saturated to 511, dark_max=50.
- 3-beat frame with dark values 20, 200 (R=210, G=200, B=230 all taps), 100 -> out_valid exactly 3 cycles after the EOF beat. A={210,200,230}, invA={312,327,284}, dark_max=200.
- Tie: two beats both dark 150, first R/G/B=150/160/170, second 150/180/190 -> A=150/160/170.
- SOF+EOF same beat, all taps=0 -> A=0, invA=511, dark_max=0. Back-to-back 1-beat frames every cycle give a 1-cycle out_valid per frame.
- smooth_en=1: frame 1 with A=200/200/200, then frame 2 with candidate 100/100/100 -> A=175 ((600+100+2)>>2), invA=374.
- in_valid=0 beats carrying sof/eof and a huge dark value (all 255) -> no effect on A or out_valid.
